// File: rtl/impartire_pkg.sv
// Shared constants for the repeated-subtraction divider: default width and FSM state codes.
package impartire_pkg;

  localparam int WIDTH_DEF = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] SUB   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/impartire_rest_if.sv
// Job/result bundle of the divider: the requester drives start/A/D,
// and the divider returns the quotient, remainder and status flags.
interface impartire_rest_if
  import impartire_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             ack;
  logic             err;
  logic             ovr;
  logic             busy;

  modport master (output start, A, D, input Q, R, ack, err, ovr, busy);
  modport slave  (input start, A, D, output Q, R, ack, err, ovr, busy);

endinterface

// File: rtl/impartire_rest_detect_front.sv
// Registered rising-edge detector for level-style request lines.
// The rise pulse is asserted for one cycle, one edge after the input is first seen high.
module detect_front (
  input  logic Clk,
  input  logic Rst_n,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      in_q <= 1'b0;
      rise <= 1'b0;
    end else begin
      in_q <= in;
      rise <= in & ~in_q;
    end
  end

endmodule

// File: rtl/impartire_rest.sv
// Unsigned divider by repeated subtraction, launched on a rising edge of start.
// A one-deep pending slot absorbs one extra request that arrives while a job is running.
module impartire_rest
  import impartire_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           Clk,
  input  logic           Rst_n,
  impartire_rest_if.slave bus
);

  logic             rise;
  logic [1:0]       state;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] dv;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             ack;
  logic             err;
  logic             ovr;
  logic             pend_full;
  logic [WIDTH-1:0] pend_a;
  logic [WIDTH-1:0] pend_d;

  detect_front u_front (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .in   (bus.start),
    .rise (rise)
  );

  // A queued job always wins over a fresh rise in IDLE; that rise refills the slot.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      x         <= '0;
      dv        <= '0;
      q         <= '0;
      r         <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      ovr       <= 1'b0;
      pend_full <= 1'b0;
      pend_a    <= '0;
      pend_d    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_full) begin
            x         <= pend_a;
            dv        <= pend_d;
            pend_full <= 1'b0;
            q         <= '0;
            ack       <= 1'b0;
            err       <= 1'b0;
            state     <= CHECK;
            if (rise) begin
              pend_a    <= bus.A;
              pend_d    <= bus.D;
              pend_full <= 1'b1;
            end
          end else if (rise) begin
            x     <= bus.A;
            dv    <= bus.D;
            q     <= '0;
            ack   <= 1'b0;
            err   <= 1'b0;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (dv == '0) begin
            err   <= 1'b1;
            q     <= '1;
            r     <= x;
            state <= DONE;
          end else begin
            state <= SUB;
          end
        end
        SUB: begin
          if (x < dv) begin
            r     <= x;
            state <= DONE;
          end else begin
            x <= x - dv;
            q <= q + WIDTH'(1);
          end
        end
        default: begin
          ack   <= 1'b1;
          state <= IDLE;
        end
      endcase

      // Requests arriving mid-job: keep one, flag any further one as an overrun.
      if (state != IDLE && rise) begin
        if (!pend_full) begin
          pend_a    <= bus.A;
          pend_d    <= bus.D;
          pend_full <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end
    end
  end

  assign bus.Q    = q;
  assign bus.R    = r;
  assign bus.ack  = ack;
  assign bus.err  = err;
  assign bus.ovr  = ovr;
  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_impartire_rest.sv
// Scoreboard bench for impartire_rest: expected results are queued per accepted job
// and popped by a monitor on each rising edge of ack.
module tb_impartire_rest;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        err;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  impartire_rest_if #(.WIDTH(16)) bus ();

  impartire_rest #(.WIDTH(16)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference behaviour: plain integer division, with the divide-by-zero convention.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    if (d == 16'd0) begin
      e.q = 16'hFFFF;
      e.r = a;
      e.err = 1'b1;
    end else begin
      e.q = a / d;
      e.r = a % d;
      e.err = 1'b0;
    end
    return e;
  endfunction

  // Upstream power unit stand-in: base**exp.
  function automatic logic [15:0] pow_model(input int base, input int ex);
    int p = 1;
    for (int i = 0; i < ex; i++) p = p * base;
    return p[15:0];
  endfunction

  // Runs one job alone and checks its launch-to-ack latency.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d, input bit keep_high);
    int cycles = 0;
    bit saw_low = 1'b0;
    bit done = 1'b0;
    int exp_lat = (d == 16'd0) ? 4 : int'(a / d) + 5;
    sb.push_back(model(a, d));
    @(negedge Clk);
    bus.start = 1'b1;
    bus.A = a;
    bus.D = d;
    while (!done && cycles < 2000) begin
      @(posedge Clk);
      cycles++;
      @(negedge Clk);
      if (cycles == 2 && !keep_high) bus.start = 1'b0;
      if (!bus.ack) saw_low = 1'b1;
      else if (saw_low) done = 1'b1;
    end
    checkOutput("latency", cycles, exp_lat);
    checkOutput("busy_at_ack", {31'd0, bus.busy}, 0);
  endtask

  task automatic issue_pulse(input logic [15:0] a, input logic [15:0] d);
    @(negedge Clk);
    bus.start = 1'b1;
    bus.A = a;
    bus.D = d;
    repeat (2) @(negedge Clk);
    bus.start = 1'b0;
  endtask

  task automatic drain(input int budget, output int first_run);
    int n = 0;
    int run = 0;
    first_run = -1;
    while ((sb.size() != 0 || bus.busy) && n < budget) begin
      @(negedge Clk);
      n++;
      if (bus.ack) run++;
      else if (run != 0 && first_run < 0) begin
        first_run = run;
        run = 0;
      end
    end
    if (first_run < 0) first_run = run;
    checkOutput("drain_empty", sb.size(), 0);
  endtask

  // Monitor: compare each fresh result against the head of the scoreboard.
  initial begin
    logic ack_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge Clk);
      if (bus.ack && !ack_prev) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_ack", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("Q", {16'd0, bus.Q}, {16'd0, e.q});
          checkOutput("R", {16'd0, bus.R}, {16'd0, e.r});
          checkOutput("err", {31'd0, bus.err}, {31'd0, e.err});
        end
      end
      ack_prev = bus.ack;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first_run;
    logic [15:0] ra;
    logic [15:0] rd;
    bus.start = 1'b0;
    bus.A = '0;
    bus.D = '0;
    repeat (3) @(negedge Clk);
    checkOutput("rst_outs", {bus.Q, bus.R}, 0);
    checkOutput("rst_flags", {28'd0, bus.ack, bus.err, bus.ovr, bus.busy}, 0);
    Rst_n = 1'b1;

    $display("[TB] directed jobs");
    applyStimulus(16'd81, 16'd4, 1'b0);
    applyStimulus(16'd3, 16'd5, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      checkOutput("held_start_ack", {30'd0, bus.ack, bus.busy}, 2);
    end
    bus.start = 1'b0;
    applyStimulus(16'd7, 16'd0, 1'b0);
    applyStimulus(16'd0, 16'd9, 1'b0);

    $display("[TB] pending slot");
    sb.push_back(model(16'd100, 16'd10));
    sb.push_back(model(16'd9, 16'd3));
    issue_pulse(16'd100, 16'd10);
    issue_pulse(16'd9, 16'd3);
    drain(500, first_run);
    checkOutput("pending_ack_len", first_run, 1);
    checkOutput("pending_ovr", {31'd0, bus.ovr}, 0);

    $display("[TB] overrun");
    sb.push_back(model(16'd1000, 16'd1));
    sb.push_back(model(16'd5, 16'd2));
    issue_pulse(16'd1000, 16'd1);
    issue_pulse(16'd5, 16'd2);
    issue_pulse(16'd6, 16'd4);
    drain(3000, first_run);
    checkOutput("ovr_set", {31'd0, bus.ovr}, 1);
    repeat (20) @(negedge Clk);
    checkOutput("ovr_sticky", {31'd0, bus.ovr}, 1);

    $display("[TB] reset mid-job");
    issue_pulse(16'd500, 16'd2);
    repeat (20) @(negedge Clk);
    checkOutput("busy_before_rst", {31'd0, bus.busy}, 1);
    #2 Rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("midrst_outs", {bus.Q, bus.R}, 0);
    checkOutput("midrst_flags", {28'd0, bus.ack, bus.err, bus.ovr, bus.busy}, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    applyStimulus(16'd10, 16'd3, 1'b0);

    $display("[TB] chained with power unit");
    applyStimulus(pow_model(3, 4), 16'd4, 1'b0);

    $display("[TB] random jobs");
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom_range(65535, 0));
      case ($urandom_range(4, 0))
        0: rd = 16'd0;
        1: begin
          ra = 16'($urandom_range(200, 0));
          rd = 16'($urandom_range(65535, 201));
        end
        default: rd = 16'($urandom_range(65535, int'(ra) / 200 + 1));
      endcase
      applyStimulus(ra, rd, 1'b0);
    end

    repeat (3) @(negedge Clk);
    checkOutput("final_queue", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
